// File: rtl/mulu_drv_pkg.sv
// Shared types and constants for the 7x7 unsigned multiplier-tile driver.
package mulu_drv_pkg;

  localparam int unsigned X_WIDTH         = 7;
  localparam int unsigned P_WIDTH         = 14;
  localparam int unsigned HALF_PERIOD_MAX = 15;
  localparam int unsigned CNT_WIDTH       = 4;

  typedef enum logic [2:0] {
    StIdle,
    StLdQ,
    StLdM,
    StRdLo,
    StRdHi,
    StDone
  } state_e;

  function automatic logic [P_WIDTH-1:0] mul_ref(input logic [X_WIDTH-1:0] a,
                                                 input logic [X_WIDTH-1:0] b);
    return P_WIDTH'(a) * P_WIDTH'(b);
  endfunction

endpackage

// File: rtl/mulu_drv_phase_timer.sv
// Down-counter timing one tile-clock phase; reloads to HalfPeriod-1, holds at zero.
module mulu_drv_phase_timer
  import mulu_drv_pkg::*;
#(
  parameter int unsigned HalfPeriod = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic count_i,
  output logic tc_o
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CNT_WIDTH'(HalfPeriod - 1);
    end else if (count_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/mulu_m7q7_drv.sv
// Drives an external 7x7 multiplier tile over a multiplexed bus and collects the product.
// Optional self-check of the product against m*q when MULU_DRV_CHECK_EN is defined.
module mulu_m7q7_drv
  import mulu_drv_pkg::*;
#(
  parameter int unsigned HALF_PERIOD = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic [X_WIDTH-1:0] op_m,
  input  logic [X_WIDTH-1:0] op_q,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [P_WIDTH-1:0] res_p,
  output logic               res_err,
  output logic               tile_clk,
  output logic [X_WIDTH-1:0] tile_din,
  input  logic [X_WIDTH-1:0] tile_dout,
  output logic               busy
);

  state_e               state_q, state_d;
  logic [X_WIDTH-1:0]   m_q, m_d, q_q, q_d;
  logic [P_WIDTH-1:0]   p_q, p_d;
  logic                 op_ready_q, op_ready_d;
  logic                 tile_clk_q, tile_clk_d;
  logic [X_WIDTH-1:0]   tile_din_q, tile_din_d;
  logic                 tmr_load, tmr_count, tmr_tc;
  logic                 done_entry;

  mulu_drv_phase_timer #(
    .HalfPeriod(HALF_PERIOD)
  ) u_timer (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .load_i (tmr_load),
    .count_i(tmr_count),
    .tc_o   (tmr_tc)
  );

  assign tmr_count = (state_q == StLdQ) || (state_q == StLdM) ||
                     (state_q == StRdLo) || (state_q == StRdHi);

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    q_d        = q_q;
    p_d        = p_q;
    tmr_load   = 1'b0;
    done_entry = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid && op_ready_q) begin
          m_d      = op_m;
          q_d      = op_q;
          state_d  = StLdQ;
          tmr_load = 1'b1;
        end
      end
      StLdQ: begin
        if (tmr_tc) begin
          state_d  = StLdM;
          tmr_load = 1'b1;
        end
      end
      StLdM: begin
        if (tmr_tc) begin
          state_d  = StRdLo;
          tmr_load = 1'b1;
        end
      end
      StRdLo: begin
        if (tmr_tc) begin
          p_d[X_WIDTH-1:0] = tile_dout;
          state_d          = StRdHi;
          tmr_load         = 1'b1;
        end
      end
      StRdHi: begin
        if (tmr_tc) begin
          p_d[P_WIDTH-1:X_WIDTH] = tile_dout;
          state_d                = StDone;
          done_entry             = 1'b1;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Tile-side outputs are registered from the next state so they never glitch.
    op_ready_d = (state_d == StIdle);
    tile_clk_d = (state_d == StLdM) || (state_d == StRdLo);
    case (state_d)
      StLdQ, StRdHi: tile_din_d = q_d;
      StLdM, StRdLo: tile_din_d = m_d;
      default:       tile_din_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      m_q        <= '0;
      q_q        <= '0;
      p_q        <= '0;
      op_ready_q <= 1'b0;
      tile_clk_q <= 1'b0;
      tile_din_q <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      q_q        <= q_d;
      p_q        <= p_d;
      op_ready_q <= op_ready_d;
      tile_clk_q <= tile_clk_d;
      tile_din_q <= tile_din_d;
    end
  end

`ifdef MULU_DRV_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (done_entry && (p_d != mul_ref(m_q, q_q))) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign res_err = err_q;
`else
  logic unused_done_entry;
  assign unused_done_entry = done_entry;
  assign res_err = 1'b0;
`endif

  assign op_ready  = op_ready_q;
  assign res_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign res_p     = p_q;
  assign tile_clk  = tile_clk_q;
  assign tile_din  = tile_din_q;

endmodule

// File: tb/tb_mulu_m7q7_drv.sv
// Directed bench: HALF_PERIOD=2 instance (a_*) for function/reset/error, HALF_PERIOD=1 (b_*).
module tb_mulu_m7q7_drv;

`ifdef MULU_DRV_CHECK_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_op_valid, a_op_ready, a_res_valid, a_res_ready, a_res_err, a_tile_clk, a_busy;
  logic [6:0]  a_op_m, a_op_q, a_tile_din, a_tile_dout;
  logic [13:0] a_res_p;
  logic        b_op_valid, b_op_ready, b_res_valid, b_res_ready, b_res_err, b_tile_clk, b_busy;
  logic [6:0]  b_op_m, b_op_q, b_tile_din, b_tile_dout;
  logic [13:0] b_res_p;

  mulu_m7q7_drv #(.HALF_PERIOD(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .op_valid(a_op_valid), .op_ready(a_op_ready),
    .op_m(a_op_m), .op_q(a_op_q), .res_valid(a_res_valid), .res_ready(a_res_ready),
    .res_p(a_res_p), .res_err(a_res_err), .tile_clk(a_tile_clk), .tile_din(a_tile_din),
    .tile_dout(a_tile_dout), .busy(a_busy)
  );

  mulu_m7q7_drv #(.HALF_PERIOD(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .op_valid(b_op_valid), .op_ready(b_op_ready),
    .op_m(b_op_m), .op_q(b_op_q), .res_valid(b_res_valid), .res_ready(b_res_ready),
    .res_p(b_res_p), .res_err(b_res_err), .tile_clk(b_tile_clk), .tile_din(b_tile_din),
    .tile_dout(b_tile_dout), .busy(b_busy)
  );

  // Tile models: q is whatever sat on din while tile_clk was low, m while it was high.
  logic [6:0]  a_lo_q = '0, a_hi_q = '0, b_lo_q = '0, b_hi_q = '0;
  logic        a_bad = 1'b0;
  logic [13:0] a_prod, b_prod;

  always @(posedge clk) begin
    if (!a_tile_clk) a_lo_q <= a_tile_din; else a_hi_q <= a_tile_din;
    if (!b_tile_clk) b_lo_q <= b_tile_din; else b_hi_q <= b_tile_din;
  end

  assign a_prod      = {7'd0, a_lo_q} * {7'd0, a_hi_q};
  assign b_prod      = {7'd0, b_lo_q} * {7'd0, b_hi_q};
  assign a_tile_dout = a_tile_clk ? a_prod[6:0] : (a_bad ? 7'd0 : a_prod[13:7]);
  assign b_tile_dout = b_tile_clk ? b_prod[6:0] : b_prod[13:7];

  int tests = 0;
  int fails = 0;
  int lat;
  logic       tclk_hist [8];
  logic [6:0] tdin_hist [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one operand pair, waits for acceptance, returns cycles from accept edge to res_valid.
  task automatic run_op(input bit sel, input logic [6:0] m, input logic [6:0] q,
                        output int cycles);
    int guard;
    @(negedge clk);
    if (sel) begin b_op_valid = 1'b1; b_op_m = m; b_op_q = q; end
    else     begin a_op_valid = 1'b1; a_op_m = m; a_op_q = q; end
    guard = 0;
    while (!(sel ? b_op_ready : a_op_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 32'(guard), 32'd0);
    @(posedge clk); #1;
    if (sel) b_op_valid = 1'b0; else a_op_valid = 1'b0;
    cycles = 1;
    for (int i = 0; i < 8; i++) begin tclk_hist[i] = 1'b0; tdin_hist[i] = '0; end
    while (!(sel ? b_res_valid : a_res_valid) && cycles < 100) begin
      if (cycles <= 8) begin
        tclk_hist[cycles-1] = sel ? b_tile_clk : a_tile_clk;
        tdin_hist[cycles-1] = sel ? b_tile_din : a_tile_din;
      end
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_a();
    @(negedge clk);
    a_res_ready = 1'b1;
    @(posedge clk); #1;
    a_res_ready = 1'b0;
    check("a_valid_drop", a_res_valid, 1'b0);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    a_op_valid = 1'b0; a_op_m = '0; a_op_q = '0; a_res_ready = 1'b0;
    b_op_valid = 1'b0; b_op_m = '0; b_op_q = '0; b_res_ready = 1'b1;

    @(posedge clk); #1;
    check("rst_op_ready", a_op_ready, 1'b0);
    check("rst_res_valid", a_res_valid, 1'b0);
    check("rst_busy", a_busy, 1'b0);
    check("rst_tile_clk", a_tile_clk, 1'b0);
    check("rst_tile_din", a_tile_din, 7'd0);
    check("rst_res_p", a_res_p, 14'd0);
    check("rst_res_err", a_res_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready_pre_edge", a_op_ready, 1'b0);
    @(posedge clk); #1;
    check("ready_first_edge", a_op_ready, 1'b1);

    run_op(1'b0, 7'd5, 7'd9, lat);
    check("lat_5x9", lat, 32'd9);
    check("p_5x9", a_res_p, 14'd45);
    check("err_5x9", a_res_err, 1'b0);
    check("din_ldq", tdin_hist[0], 7'd9);
    check("din_ldm", tdin_hist[2], 7'd5);
    check("din_rdhi", tdin_hist[6], 7'd9);
    check("tclk_ldq", tclk_hist[1], 1'b0);
    check("tclk_ldm", tclk_hist[2], 1'b1);
    check("tclk_rdlo", tclk_hist[5], 1'b1);
    check("tclk_rdhi", tclk_hist[6], 1'b0);
    check("busy_done", a_busy, 1'b1);
    check("ready_done", a_op_ready, 1'b0);
    release_a();
    check("busy_idle", a_busy, 1'b0);

    run_op(1'b0, 7'd127, 7'd127, lat);
    check("p_127x127", a_res_p, 14'd16129);
    release_a();
    run_op(1'b0, 7'd0, 7'd99, lat);
    check("p_0x99", a_res_p, 14'd0);
    release_a();

    // Hold the result for 20 cycles while another pair is offered.
    run_op(1'b0, 7'd12, 7'd11, lat);
    check("p_12x11", a_res_p, 14'd132);
    @(negedge clk);
    a_op_valid = 1'b1; a_op_m = 7'd3; a_op_q = 7'd3;
    repeat (20) @(posedge clk);
    #1;
    check("hold_p", a_res_p, 14'd132);
    check("hold_valid", a_res_valid, 1'b1);
    check("hold_ready", a_op_ready, 1'b0);
    check("hold_tclk", a_tile_clk, 1'b0);
    @(negedge clk);
    a_op_valid = 1'b0;
    release_a();
    check("hold_p_after", a_res_p, 14'd132);

    // Asynchronous reset in the middle of RD_LO.
    @(negedge clk);
    a_op_valid = 1'b1; a_op_m = 7'd7; a_op_q = 7'd7;
    @(posedge clk); #1;
    a_op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("rdlo_tclk", a_tile_clk, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 1'b0);
    check("mid_rst_tclk", a_tile_clk, 1'b0);
    check("mid_rst_tdin", a_tile_din, 7'd0);
    check("mid_rst_ready", a_op_ready, 1'b0);
    check("mid_rst_p", a_res_p, 14'd0);
    check("mid_rst_valid", a_res_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (a_res_valid) seen = 1'b1;
    end
    check("no_stale_result", seen, 1'b0);
    run_op(1'b0, 7'd20, 7'd30, lat);
    check("lat_after_rst", lat, 32'd9);
    check("p_20x30", a_res_p, 14'd600);
    release_a();

    // Corrupt the upper product half from the tile.
    a_bad = 1'b1;
    run_op(1'b0, 7'd100, 7'd100, lat);
    a_bad = 1'b0;
    check("p_bad", a_res_p, 14'd16);
    check("err_bad", a_res_err, ERR_EXP);
    release_a();
    run_op(1'b0, 7'd3, 7'd4, lat);
    check("p_3x4", a_res_p, 14'd12);
    check("err_sticky", a_res_err, ERR_EXP);
    release_a();

    // HALF_PERIOD=1, consumer always ready, back-to-back ops.
    run_op(1'b1, 7'd6, 7'd7, lat);
    check("b_lat1", lat, 32'd5);
    check("b_p_6x7", b_res_p, 14'd42);
    check("b_tclk_c1", tclk_hist[0], 1'b0);
    check("b_tclk_c2", tclk_hist[1], 1'b1);
    check("b_tclk_c3", tclk_hist[2], 1'b1);
    check("b_tclk_c4", tclk_hist[3], 1'b0);
    run_op(1'b1, 7'd127, 7'd1, lat);
    check("b_lat2", lat, 32'd5);
    check("b_p_127x1", b_res_p, 14'd127);
    check("b_err", b_res_err, 1'b0);
    @(posedge clk); #1;
    check("b_valid_drop", b_res_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
